// File: rtl/scan_test_controller.sv
// Scan test sequencer: shifts a stimulus into a scan chain, captures one cycle,
// shifts the response back out and compares it against a masked expectation.
module scan_test_controller #(
    parameter int CHAIN_LEN  = 8,
    parameter int FAIL_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CHAIN_LEN-1:0]  pattern,
    input  logic [CHAIN_LEN-1:0]  expected,
    input  logic [CHAIN_LEN-1:0]  mask,
    input  logic                  clr_fail,
    output logic                  scan_en,
    output logic                  scan_si,
    input  logic                  scan_so,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CHAIN_LEN-1:0]  response,
    output logic [FAIL_CNT_W-1:0] fail_count
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        CAPTURE,
        SHIFT_OUT,
        DONE
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [CHAIN_LEN-1:0]   pattern_q;
    logic [CHAIN_LEN-1:0]   expected_q;
    logic [CHAIN_LEN-1:0]   mask_q;
    logic [CHAIN_LEN-1:0]   response_sh;
    logic [CHAIN_LEN-1:0]   resp_next;
    logic                   run_pass;
    logic                   fail_sat;

    // The verdict is formed from the final sample so pass is already valid during done.
    assign resp_next = {response_sh[CHAIN_LEN-2:0], scan_so};
    assign run_pass  = ((resp_next ^ expected_q) & mask_q) == '0;
    assign fail_sat  = (fail_count == {FAIL_CNT_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            pattern_q   <= '0;
            expected_q  <= '0;
            mask_q      <= '0;
            response_sh <= '0;
            response    <= '0;
            pass        <= 1'b0;
            fail_count  <= '0;
            scan_en     <= 1'b0;
            scan_si     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clr_fail) begin
                fail_count <= '0;
            end
            if (abort) begin
                state   <= IDLE;
                bit_cnt <= '0;
                scan_en <= 1'b0;
                scan_si <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            // pattern_q doubles as the MSB-first serialiser.
                            pattern_q  <= {pattern[CHAIN_LEN-2:0], 1'b0};
                            expected_q <= expected;
                            mask_q     <= mask;
                            scan_si    <= pattern[CHAIN_LEN-1];
                            scan_en    <= 1'b1;
                            busy       <= 1'b1;
                            bit_cnt    <= '0;
                            state      <= SHIFT_IN;
                        end
                    end
                    SHIFT_IN: begin
                        if (bit_cnt == LAST_BIT) begin
                            scan_en <= 1'b0;
                            scan_si <= 1'b0;
                            bit_cnt <= '0;
                            state   <= CAPTURE;
                        end else begin
                            scan_si   <= pattern_q[CHAIN_LEN-1];
                            pattern_q <= {pattern_q[CHAIN_LEN-2:0], 1'b0};
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                    end
                    CAPTURE: begin
                        scan_en <= 1'b1;
                        bit_cnt <= '0;
                        state   <= SHIFT_OUT;
                    end
                    SHIFT_OUT: begin
                        response_sh <= resp_next;
                        if (bit_cnt == LAST_BIT) begin
                            scan_en  <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            response <= resp_next;
                            pass     <= run_pass;
                            if (!run_pass && !fail_sat && !clr_fail) begin
                                fail_count <= fail_count + 1'b1;
                            end
                            state <= DONE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scan_test_controller.sv
// Self-checking bench for scan_test_controller with a behavioural scan chain,
// a run-age reference model, directed scenarios and a randomized phase.
module tb_scan_test_controller;

    localparam int N  = 8;
    localparam int FW = 2;
    localparam int FMAX = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [N-1:0]  pattern = '0;
    logic [N-1:0]  expected = '0;
    logic [N-1:0]  mask = '0;
    logic          clr_fail = 1'b0;
    logic          scan_en;
    logic          scan_si;
    logic          scan_so;
    logic          busy;
    logic          done;
    logic          pass;
    logic [N-1:0]  response;
    logic [FW-1:0] fail_count;

    logic [N-1:0]  func_in = '0;
    logic [N-1:0]  chain_q = '0;
    logic [N-1:0]  data_out = '0;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    scan_test_controller #(.CHAIN_LEN(N), .FAIL_CNT_W(FW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .pattern(pattern), .expected(expected), .mask(mask), .clr_fail(clr_fail),
        .scan_en(scan_en), .scan_si(scan_si), .scan_so(scan_so),
        .busy(busy), .done(done), .pass(pass), .response(response),
        .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    // Behavioural scan chain under control of the DUT.
    assign scan_so = chain_q[N-1];
    always @(posedge clk) begin
        if (scan_en) begin
            chain_q <= {chain_q[N-2:0], scan_si};
        end else begin
            data_out <= chain_q;
            chain_q  <= func_in;
        end
    end

    // Reference model: age counts cycles since an accepted start (-1 = idle).
    int           age;
    logic [N-1:0] m_pat, m_exp, m_mask, m_cap, m_resp;
    logic         m_pass;
    int           m_fail;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age = -1; m_resp = '0; m_pass = 1'b0; m_fail = 0; m_cap = '0;
            m_pat = '0; m_exp = '0; m_mask = '0;
        end else begin
            if (age == N) m_cap = func_in;
            if (abort) begin
                age = -1;
            end else if (age < 0) begin
                if (start) begin
                    age = 0; m_pat = pattern; m_exp = expected; m_mask = mask;
                end
            end else if (age == 2*N) begin
                age = 2*N + 1;
                m_resp = m_cap;
                m_pass = ((m_cap ^ m_exp) & m_mask) == '0;
                if (!m_pass && m_fail < FMAX) m_fail = m_fail + 1;
            end else if (age == 2*N + 1) begin
                age = -1;
            end else begin
                age = age + 1;
            end
            if (clr_fail) m_fail = 0;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    logic e_busy, e_done, e_en, e_si;
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            e_busy = (age >= 0) && (age <= 2*N);
            e_done = (age == 2*N + 1);
            e_en   = ((age >= 0) && (age < N)) || ((age > N) && (age <= 2*N));
            e_si   = ((age >= 0) && (age < N)) ? m_pat[N-1-age] : 1'b0;
            check_output("cmp_busy", 32'(busy), 32'(e_busy));
            check_output("cmp_done", 32'(done), 32'(e_done));
            check_output("cmp_scan_en", 32'(scan_en), 32'(e_en));
            check_output("cmp_scan_si", 32'(scan_si), 32'(e_si));
            check_output("cmp_pass", 32'(pass), 32'(m_pass));
            check_output("cmp_response", 32'(response), 32'(m_resp));
            check_output("cmp_fail_count", 32'(fail_count), 32'(m_fail));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic st, input logic [N-1:0] pat,
                                  input logic [N-1:0] exp_v, input logic [N-1:0] msk,
                                  input logic [N-1:0] fin);
        start = st; pattern = pat; expected = exp_v; mask = msk; func_in = fin;
    endtask

    // Starts a run and returns at the falling edge inside the done cycle.
    task automatic run_to_done(input logic [N-1:0] pat, input logic [N-1:0] exp_v,
                               input logic [N-1:0] msk, input logic [N-1:0] fin);
        apply_stimulus(1'b1, pat, exp_v, msk, fin);
        tick();
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            check_output("shift_in_si", 32'(scan_si), 32'(pat[N-1-k]));
            tick();
        end
        tick();
        @(negedge clk);
        check_output("data_out_after_capture", 32'(data_out), 32'(pat));
        for (int k = 0; k < N; k++) tick();
        @(negedge clk);
        check_output("done_latency", 32'(done), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_scan_en"}, 32'(scan_en), 32'd0);
        check_output({tag, "_scan_si"}, 32'(scan_si), 32'd0);
        check_output({tag, "_busy"}, 32'(busy), 32'd0);
        check_output({tag, "_done"}, 32'(done), 32'd0);
        check_output({tag, "_pass"}, 32'(pass), 32'd0);
        check_output({tag, "_response"}, 32'(response), 32'd0);
        check_output({tag, "_fail_count"}, 32'(fail_count), 32'd0);
    endtask

    logic [FW-1:0] sat_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    int done_seen;

    initial begin
        #1;
        check_reset_outputs("reset");
        #21 rst_n = 1'b1;
        cmp_en = 1'b1;
        tick();

        // Scenario 1: nominal passing run.
        run_to_done(8'hA5, 8'h3C, 8'hFF, 8'h3C);
        check_output("s1_response", 32'(response), 32'h3C);
        check_output("s1_pass", 32'(pass), 32'd1);
        check_output("s1_fail_count", 32'(fail_count), 32'd0);
        tick();
        @(negedge clk);
        check_output("s1_done_one_cycle", 32'(done), 32'd0);
        tick();

        // Scenario 2: mismatch in bit0, then the same mismatch masked off.
        run_to_done(8'hA5, 8'h3D, 8'hFF, 8'h3C);
        check_output("s2_pass_fail", 32'(pass), 32'd0);
        check_output("s2_fail_count", 32'(fail_count), 32'd1);
        tick();
        run_to_done(8'hA5, 8'h3D, 8'hFE, 8'h3C);
        check_output("s2_pass_masked", 32'(pass), 32'd1);
        check_output("s2_fail_hold", 32'(fail_count), 32'd1);
        tick();

        // Scenario 3: saturation of the 2-bit counter, then clear racing a failing done.
        clr_fail = 1'b1;
        tick();
        clr_fail = 1'b0;
        for (int r = 0; r < 5; r++) begin
            run_to_done(8'h96, 8'h3D, 8'hFF, 8'h3C);
            check_output("s3_fail_sat", 32'(fail_count), 32'(sat_seq[r]));
            tick();
        end
        apply_stimulus(1'b1, 8'h96, 8'h00, 8'hFF, 8'h3C);
        tick();
        start = 1'b0;
        for (int k = 0; k < 2*N; k++) tick();
        clr_fail = 1'b1;
        tick();
        clr_fail = 1'b0;
        @(negedge clk);
        check_output("s3_clr_wins", 32'(fail_count), 32'd0);
        tick();

        // Scenario 4: abort in the third shift-out cycle.
        run_to_done(8'h11, 8'h3C, 8'hFF, 8'h3C);
        tick();
        apply_stimulus(1'b1, 8'h22, 8'h00, 8'hFF, 8'h5A);
        tick();
        start = 1'b0;
        for (int k = 0; k < N + 3; k++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check_output("s4_busy_after_abort", 32'(busy), 32'd0);
        check_output("s4_scan_en_after_abort", 32'(scan_en), 32'd0);
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            @(negedge clk);
            if (done) done_seen++;
        end
        check_output("s4_no_done", 32'(done_seen), 32'd0);
        check_output("s4_response_hold", 32'(response), 32'h3C);
        check_output("s4_pass_hold", 32'(pass), 32'd1);
        tick();
        run_to_done(8'hA5, 8'h5A, 8'hFF, 8'h5A);
        check_output("s4_rerun_resp", 32'(response), 32'h5A);
        tick();

        // Scenario 5: start held high throughout a run.
        apply_stimulus(1'b1, 8'h0F, 8'hC3, 8'hFF, 8'hC3);
        tick();
        done_seen = 0;
        for (int k = 1; k <= 2*N + 1; k++) begin
            tick();
            @(negedge clk);
            if (done) done_seen++;
        end
        check_output("s5_done_at_e17", 32'(done), 32'd1);
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            @(negedge clk);
            if (done) done_seen++;
        end
        check_output("s5_single_done", 32'(done_seen), 32'd1);
        check_output("s5_response", 32'(response), 32'hC3);
        tick();

        // Scenario 6: asynchronous reset in the middle of shift-in.
        run_to_done(8'h01, 8'h00, 8'hFF, 8'h77);
        tick();
        apply_stimulus(1'b1, 8'hA5, 8'h3C, 8'hFF, 8'h3C);
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("s6_async");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_to_done(8'hA5, 8'h3C, 8'hFF, 8'h3C);
        check_output("s6_response", 32'(response), 32'h3C);
        check_output("s6_pass", 32'(pass), 32'd1);
        tick();

        // Randomized phase checked by the model on every cycle.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(15) == 0) func_in = 8'($urandom);
            start    = ($urandom_range(3) == 0);
            abort    = ($urandom_range(39) == 0);
            clr_fail = ($urandom_range(29) == 0);
            pattern  = 8'($urandom);
            expected = $urandom_range(1) ? func_in : 8'($urandom);
            mask     = ($urandom_range(2) == 0) ? 8'($urandom) : 8'hFF;
            tick();
        end
        start = 1'b0; abort = 1'b0; clr_fail = 1'b0;
        for (int k = 0; k < 2*N + 4; k++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scan_test_controller.md
Name: scan_test_controller

Overview:
- Sequences one scan test on a scan-register chain of CHAIN_LEN flops: shift in a stimulus, apply/capture, shift out the response, compare.
- Drives the chain's scan enable and serial input, and samples its serial output.
- Sits between a test host (register block or JTAG-side logic) and the chain.
- Reports pass/fail and keeps a saturating count of failing runs.

Parameters:
- CHAIN_LEN, 8, number of flops in the controlled chain (>= 2).
- FAIL_CNT_W, 8, width of the saturating fail counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to run a test; accepted only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE.
- pattern  input  CHAIN_LEN  stimulus to load into the chain; sampled on start acceptance.
- expected  input  CHAIN_LEN  expected captured value; sampled on start acceptance.
- mask  input  CHAIN_LEN  compare mask (1 = bit checked); sampled on start acceptance.
- clr_fail  input  1  clears fail_count.
- scan_en  output  1  to chain: 1 = shift, 0 = normal/capture.
- scan_si  output  1  to chain serial input.
- scan_so  input  1  from chain serial output (chain's MSB flop).
- busy  output  1  high in SHIFT_IN, CAPTURE, SHIFT_OUT.
- done  output  1  one-cycle pulse at end of a completed run.
- pass  output  1  result of the last completed run; valid with done and held until the next completion.
- response  output  CHAIN_LEN  captured chain contents from the last completed run.
- fail_count  output  FAIL_CNT_W  number of failed runs, saturating.

Behaviour:
- Chain model: when scan_en=1, each edge shifts toward the MSB with scan_si entering bit0, and scan_so = MSB. When scan_en=0, each edge loads the chain from its functional input and updates the chain's data_out from the chain contents.
- States: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE. Outputs are decoded from the registered state and counter.
- IDLE: scan_en=0, scan_si=0. On start, register pattern/expected/mask, clear bit_cnt, and go to SHIFT_IN.
- SHIFT_IN: lasts CHAIN_LEN cycles. scan_en=1; scan_si = pattern_q[CHAIN_LEN-1-bit_cnt], so bits go out MSB first. After CHAIN_LEN edges the chain holds pattern_q; then go to CAPTURE.
- CAPTURE: lasts exactly 1 cycle with scan_en=0. The chain's data_out takes pattern_q and the chain captures its functional input. Then go to SHIFT_OUT with bit_cnt cleared.
- SHIFT_OUT: lasts CHAIN_LEN cycles with scan_en=1 and scan_si=0. Each edge does response_sh <= {response_sh[CHAIN_LEN-2:0], scan_so}, so the first sample lands in the MSB. After CHAIN_LEN edges go to DONE.
- DONE: lasts 1 cycle. done=1, scan_en=0. response is updated from response_sh, and pass = (((response_sh ^ expected_q) & mask_q) == 0).
  - If the run failed and fail_count is not at its maximum, fail_count increments.
  - Next state is IDLE. start is ignored in DONE.
- Latency: if start is accepted at edge E0, done is high during the cycle after edge E(2*CHAIN_LEN+1). With CHAIN_LEN=8 that is the cycle after E17.
- abort:
  - In any non-IDLE state, go to IDLE at the next edge with scan_en=0.
  - No done pulse; pass, response and fail_count are unchanged.
  - abort has priority over start and over the DONE update.
- clr_fail: zeros fail_count at the next edge. If a failing DONE occurs in the same cycle, clr_fail wins and the count becomes 0.
- start while busy: ignored, with no queueing.
- Reset (asynchronous, any state): state=IDLE; scan_en=0, scan_si=0, busy=0, done=0, pass=0, response=0, fail_count=0, bit_cnt=0, internal registers=0.
- bit_cnt width: $clog2(CHAIN_LEN+1).

Test Plan:
1. CHAIN_LEN=8, chain functional input tied 8'h3C; pattern=8'hA5, expected=8'h3C, mask=8'hFF, pulse start. Required:
   - scan_si sequence 1,0,1,0,0,1,0,1.
   - Chain data_out=8'hA5 after CAPTURE.
   - response=8'h3C, pass=1, done in the cycle after E17, fail_count=0.
2. Same run with expected=8'h3D, mask=8'hFF -> pass=0, fail_count=1. Repeat with mask=8'hFE -> pass=1, fail_count stays 1.
3. FAIL_CNT_W=2, five failing runs -> fail_count reads 1,2,3,3,3. Then clr_fail asserted in the same cycle as a failing DONE -> fail_count=0.
4. abort asserted in the 3rd SHIFT_OUT cycle -> IDLE at the next edge, no done, response/pass hold the previous run's values. A new start then completes normally.
5. start pulsed at every cycle during a run -> exactly one done, 18 cycles after the first accepted start.
6. rst_n dropped mid SHIFT_IN -> scan_en=0, busy=0, all outputs 0 immediately (asynchronous). After release, a start runs scenario 1 correctly.
